// File: rtl/accelerator_pkg.sv
// Shared types and helpers for the vector reduction path.
// Defines the reduction opcodes, the reduce-stage FSM states and the per-op identity values.
package accelerator_pkg;

  // Widest element that red_identity can describe; callers truncate to their own width.
  localparam int unsigned RED_MAX_W = 256;

  typedef enum logic [2:0] {
    RED_SUM  = 3'd0,
    RED_AND  = 3'd1,
    RED_OR   = 3'd2,
    RED_XOR  = 3'd3,
    RED_MINU = 3'd4,
    RED_MIN  = 3'd5,
    RED_MAXU = 3'd6,
    RED_MAX  = 3'd7
  } red_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } red_state_t;

  // Value that leaves any operand unchanged under op, for an element of the given width.
  function automatic logic [RED_MAX_W-1:0] red_identity(input red_op_t op,
                                                        input int unsigned width);
    logic [RED_MAX_W-1:0] ones;
    logic [RED_MAX_W-1:0] result;
    ones = '1;
    ones = ones >> (RED_MAX_W - width);
    case (op)
      RED_AND, RED_MINU: result = ones;
      RED_MIN:           result = ones >> 1;
      RED_MAX:           result = ones ^ (ones >> 1);
      default:           result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/red_combine.sv
// Two-input combine cell for the reduction tree and accumulator.
// Applies the selected reduction op to a and b in a single combinational step.
module red_combine
  import accelerator_pkg::*;
#(
  parameter int unsigned LANE_W = 32
) (
  input  red_op_t           op,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] y
);

  logic lt_u;
  logic lt_s;

  always_comb begin
    lt_u = a < b;
    lt_s = $signed(a) < $signed(b);
  end

  always_comb begin
    y = '0;
    case (op)
      RED_SUM:  y = a + b;
      RED_AND:  y = a & b;
      RED_OR:   y = a | b;
      RED_XOR:  y = a ^ b;
      RED_MINU: y = lt_u ? a : b;
      RED_MIN:  y = lt_s ? a : b;
      RED_MAXU: y = lt_u ? b : a;
      RED_MAX:  y = lt_s ? b : a;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/vec_reduce_stage.sv
// Multi-beat vector reduction stage: folds vl streamed elements plus an initial scalar
// into one result, with tail masking, ready/valid handshakes and synchronous flush.
module vec_reduce_stage
  import accelerator_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned LANE_W    = 32,
  parameter int unsigned MAX_VL    = 32,
  parameter int unsigned VL_W      = $clog2(MAX_VL + 1)
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  red_op_t                     cmd_op,
  input  logic [LANE_W-1:0]           cmd_init,
  input  logic [VL_W-1:0]             cmd_vl,
  input  logic                        beat_valid,
  output logic                        beat_ready,
  input  logic [NUM_LANES*LANE_W-1:0] beat_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [LANE_W-1:0]           res_data,
  input  logic                        flush,
  output logic                        busy
);

  localparam logic [VL_W-1:0] LANES_VL  = VL_W'(NUM_LANES);
  localparam logic [VL_W-1:0] MAX_VL_V  = VL_W'(MAX_VL);

  red_state_t        state;
  red_state_t        state_nxt;
  red_op_t           op_q;
  logic [LANE_W-1:0] acc;
  logic [LANE_W-1:0] acc_nxt;
  logic [LANE_W-1:0] identity;
  logic [LANE_W-1:0] tree_root;
  logic [VL_W-1:0]   remaining;
  logic [VL_W-1:0]   active;
  logic [VL_W-1:0]   vl_clamped;
  logic              cmd_fire;
  logic              beat_fire;

  logic [LANE_W-1:0] leaf [NUM_LANES];
  logic [LANE_W-1:0] node [1:NUM_LANES-1];

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign beat_fire = beat_valid & beat_ready;
  assign res_data  = acc;

  always_comb begin
    identity   = LANE_W'(red_identity(op_q, LANE_W));
    active     = (remaining < LANES_VL) ? remaining : LANES_VL;
    vl_clamped = (cmd_vl > MAX_VL_V) ? MAX_VL_V : cmd_vl;
  end

  // Lane i carries a real element only while more than i elements remain.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      leaf[i] = (VL_W'(i) < remaining) ? beat_data[i*LANE_W +: LANE_W] : identity;
    end
  end

  // Heap-indexed tree: node g combines children 2g and 2g+1; indices >= NUM_LANES are leaves.
  for (genvar g = 1; g < NUM_LANES; g++) begin : g_tree
    logic [LANE_W-1:0] lhs;
    logic [LANE_W-1:0] rhs;
    if (2 * g >= NUM_LANES) begin : g_leaf
      assign lhs = leaf[2*g - NUM_LANES];
      assign rhs = leaf[2*g + 1 - NUM_LANES];
    end else begin : g_inner
      assign lhs = node[2*g];
      assign rhs = node[2*g + 1];
    end
    red_combine #(.LANE_W(LANE_W)) u_cell (
      .op (op_q),
      .a  (lhs),
      .b  (rhs),
      .y  (node[g])
    );
  end

  assign tree_root = node[1];

  red_combine #(.LANE_W(LANE_W)) u_acc (
    .op (op_q),
    .a  (acc),
    .b  (tree_root),
    .y  (acc_nxt)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (cmd_valid) state_nxt = (vl_clamped == '0) ? S_DONE : S_ACCUM;
        S_ACCUM: if (beat_valid && (remaining <= LANES_VL)) state_nxt = S_DONE;
        S_DONE:  if (res_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready  = (state == S_IDLE)  && !flush;
    beat_ready = (state == S_ACCUM) && !flush;
    res_valid  = (state == S_DONE)  && !flush;
    busy       = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc       <= '0;
      remaining <= '0;
      op_q      <= RED_SUM;
    end else if (flush) begin
      acc       <= '0;
      remaining <= '0;
    end else if (cmd_fire) begin
      op_q      <= cmd_op;
      acc       <= cmd_init;
      remaining <= vl_clamped;
    end else if (beat_fire) begin
      acc       <= acc_nxt;
      remaining <= remaining - active;
    end
  end

endmodule
